// File: rtl/audio_i2s_master.sv
// I2S / left-justified codec master: generates BCLK/LRCK, serialises DAC and deserialises ADC samples.
// Latency: sample capture to MSB on the wire is BCLK_DIV-1 (left-justified) or 2*BCLK_DIV-1 (I2S) clk; ADC LSB to sample_end is 1 clk.
// No backpressure: sample_req/sample_end are fixed-rate pulses; audio_output must be valid the cycle after sample_req.
module audio_i2s_master #(
    parameter int DATA_W   = 16,
    parameter int SLOT_W   = 32,
    parameter int BCLK_DIV = 6,
    parameter int FORMAT   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        channel_en,
    input  logic [DATA_W-1:0] audio_output,
    output logic [1:0]        sample_req,
    output logic [DATA_W-1:0] audio_input,
    output logic [1:0]        sample_end,
    output logic              AUD_BCLK,
    output logic              AUD_DACLRCK,
    output logic              AUD_ADCLRCK,
    output logic              AUD_DACDAT,
    input  logic              AUD_ADCDAT
);

    localparam int DW = $clog2(BCLK_DIV);
    localparam int BW = $clog2(SLOT_W);
    localparam int PW = BW + 1;

    localparam logic [DW-1:0] DIV_LAST  = DW'(BCLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF  = DW'(BCLK_DIV / 2);
    localparam logic [DW-1:0] DIV_ONE   = DW'(1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(SLOT_W - 1);
    localparam logic [PW-1:0] FIRST_POS = PW'(FORMAT == 1 ? 0 : 1);
    localparam logic [PW-1:0] DATA_LEN  = PW'(DATA_W);
    localparam logic [PW-1:0] LAST_REL  = PW'(DATA_W - 1);

    logic [DW-1:0]     div_cnt;
    logic [DW-1:0]     div_nxt;
    logic [BW-1:0]     bit_cnt;
    logic              chan;
    logic              lrck;
    logic [1:0]        en;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-2:0] rx_sh;
    logic [PW-1:0]     slot_rel;
    logic              in_data;
    logic              req_pt;

    // slot_rel wraps to a large value before the first data position, so one compare covers both bounds
    assign slot_rel = {1'b0, bit_cnt} - FIRST_POS;
    assign in_data  = (slot_rel < DATA_LEN);
    assign req_pt   = (div_cnt == '0) && (bit_cnt == BIT_LAST);
    assign div_nxt  = (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);

    assign sample_req[0] = ~reset & req_pt & chan & channel_en[0];
    assign sample_req[1] = ~reset & req_pt & ~chan & channel_en[1];

    assign AUD_DACLRCK = lrck;
    assign AUD_ADCLRCK = lrck;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt     <= '0;
            bit_cnt     <= BIT_LAST;
            chan        <= 1'b1;
            lrck        <= 1'b1;
            en          <= 2'b00;
            tx_sh       <= '0;
            rx_sh       <= '0;
            audio_input <= '0;
            sample_end  <= 2'b00;
            AUD_BCLK    <= 1'b0;
            AUD_DACDAT  <= 1'b0;
        end else begin
            div_cnt    <= div_nxt;
            AUD_BCLK   <= (div_nxt >= DIV_HALF);
            sample_end <= 2'b00;

            if (div_cnt == DIV_LAST) begin
                bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BW'(1);
                if (bit_cnt == BIT_LAST) begin
                    chan <= ~chan;
                end
            end

            // the enable of the upcoming slot is frozen here for that whole slot
            if (req_pt) begin
                en[~chan] <= channel_en[~chan];
            end

            if ((div_cnt == DIV_ONE) && (bit_cnt == BIT_LAST)) begin
                tx_sh <= audio_output;
            end

            if (div_cnt == '0) begin
                lrck <= chan;
                if (en[chan] && in_data) begin
                    AUD_DACDAT <= tx_sh[DATA_W-1];
                    tx_sh      <= tx_sh << 1;
                end else begin
                    AUD_DACDAT <= 1'b0;
                end
            end

            if ((div_cnt == DIV_HALF) && en[chan] && in_data) begin
                rx_sh <= {rx_sh[DATA_W-3:0], AUD_ADCDAT};
                if (slot_rel == LAST_REL) begin
                    audio_input      <= {rx_sh, AUD_ADCDAT};
                    sample_end[chan] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_i2s_master.sv
// Bench for audio_i2s_master: a default I2S instance and a 24-bit left-justified instance, both in DAC->ADC loopback,
// checked every cycle against a frame-phase model plus literal expectations.
module tb_audio_i2s_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [1:0]  channel_en;
    logic [15:0] aout0;
    logic [23:0] aout1;
    logic [1:0]  req0, end0, req1, end1;
    logic [15:0] ain0;
    logic [23:0] ain1;
    logic        bclk0, dlr0, alr0, dac0;
    logic        bclk1, dlr1, alr1, dac1;

    audio_i2s_master dut0 (
        .clk(clk), .reset(reset), .channel_en(channel_en), .audio_output(aout0),
        .sample_req(req0), .audio_input(ain0), .sample_end(end0),
        .AUD_BCLK(bclk0), .AUD_DACLRCK(dlr0), .AUD_ADCLRCK(alr0),
        .AUD_DACDAT(dac0), .AUD_ADCDAT(dac0)
    );

    audio_i2s_master #(.DATA_W(24), .SLOT_W(24), .BCLK_DIV(4), .FORMAT(1)) dut1 (
        .clk(clk), .reset(reset), .channel_en(channel_en), .audio_output(aout1),
        .sample_req(req1), .audio_input(ain1), .sample_end(end1),
        .AUD_BCLK(bclk1), .AUD_DACLRCK(dlr1), .AUD_ADCLRCK(alr1),
        .AUD_DACDAT(dac1), .AUD_ADCDAT(dac1)
    );

    int cfg_slot [2] = '{32, 24};
    int cfg_div  [2] = '{6, 4};
    int cfg_dw   [2] = '{16, 24};
    int cfg_off  [2] = '{1, 0};

    int          tcyc [2];
    logic [1:0]  men [2];
    logic [1:0]  cap_pend [2];
    logic [23:0] msamp [2][2];
    logic [23:0] mainv [2];

    int          last_req [2], req_int [2];
    int          last_lr [2], lr_int [2];
    int          last_bclk [2], bclk_int [2];
    logic        prev_lr [2], prev_bclk [2], edge_dac [2];
    logic [23:0] end_val [2][2];
    int          end_cnt [2][2];
    int          req_cnt [2][2];
    logic [31:0] word, left_word;

    int   gcyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   mode = 0;
    bit   armed = 0;
    bit   rst_prev = 0;
    logic nxt_reset;
    logic [1:0] nxt_en;

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 20)
                $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, i, gcyc, act, exp);
        end
    endtask

    function automatic int ph_of(input int i);
        return (tcyc[i] + (2 * cfg_slot[i] - 1) * cfg_div[i]) % (2 * cfg_slot[i] * cfg_div[i]);
    endfunction

    task automatic model_step(input int i);
        int S, D, F, ph, ch, pos, d, q, qch, qpos, k, dw, off;
        logic [1:0]  a_req, a_end, e_req, e_end;
        logic [23:0] a_ain, a_aout;
        logic        a_bclk, a_dlr, a_alr, a_dac, e_dac;
        S = cfg_slot[i]; D = cfg_div[i]; dw = cfg_dw[i]; off = cfg_off[i]; F = 2 * S * D;
        if (i == 0) begin
            a_req = req0; a_end = end0; a_ain = {8'h00, ain0}; a_aout = {8'h00, aout0};
            a_bclk = bclk0; a_dlr = dlr0; a_alr = alr0; a_dac = dac0;
        end else begin
            a_req = req1; a_end = end1; a_ain = ain1; a_aout = aout1;
            a_bclk = bclk1; a_dlr = dlr1; a_alr = alr1; a_dac = dac1;
        end
        if (rst_prev) begin
            tcyc[i] = 0; men[i] = 2'b00; cap_pend[i] = 2'b00; mainv[i] = '0;
        end
        // phase 0 = left slot, first bit, first clk; reset parks one BCLK before it
        ph  = ph_of(i);
        ch  = ph / (S * D);
        pos = (ph / D) % S;
        d   = ph % D;
        q    = (ph + F - 1) % F;
        qch  = q / (S * D);
        qpos = (q / D) % S;
        k    = qpos - off;
        e_dac = 1'b0;
        if (men[i][qch] && k >= 0 && k < dw) e_dac = msamp[i][qch][dw-1-k];
        e_req = 2'b00;
        if (!reset && d == 0 && pos == S - 1) e_req[1-ch] = channel_en[1-ch];
        e_end = 2'b00;
        if (d == D / 2 + 1 && pos == off + dw - 1 && men[i][ch]) begin
            e_end[ch] = 1'b1;
            mainv[i]  = msamp[i][ch];
        end

        chk("bclk", i, a_bclk, d >= D / 2);
        chk("daclrck", i, a_dlr, qch);
        chk("adclrck", i, a_alr, qch);
        chk("dacdat", i, a_dac, e_dac);
        chk("sample_req", i, a_req, e_req);
        chk("sample_end", i, a_end, e_end);
        chk("audio_input", i, a_ain, mainv[i]);

        if (a_req[0]) begin
            req_int[i] = gcyc - last_req[i]; last_req[i] = gcyc;
        end
        if (a_dlr !== prev_lr[i]) begin
            lr_int[i] = gcyc - last_lr[i]; last_lr[i] = gcyc;
            edge_dac[i] = a_dac; prev_lr[i] = a_dlr;
        end
        if (a_bclk && !prev_bclk[i]) begin
            bclk_int[i] = gcyc - last_bclk[i]; last_bclk[i] = gcyc;
        end
        prev_bclk[i] = a_bclk;
        for (int c = 0; c < 2; c++) begin
            if (a_end[c]) begin end_val[i][c] = a_ain; end_cnt[i][c]++; end
            if (a_req[c]) req_cnt[i][c]++;
        end
        if (i == 0 && d == D / 2 && ch == 0) begin
            word = {word[30:0], a_dac};
            if (pos == S - 1) left_word = word;
        end

        if (!reset) begin
            for (int c = 0; c < 2; c++) begin
                if (cap_pend[i][c]) begin
                    msamp[i][c] = a_aout; cap_pend[i][c] = 1'b0;
                end
            end
            if (d == 0 && pos == S - 1) begin
                men[i][1-ch] = channel_en[1-ch];
                cap_pend[i][1-ch] = 1'b1;
            end
            tcyc[i]++;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        reset = nxt_reset;
        channel_en = nxt_en;
        #1;
        if (rst_prev) armed = 1;
        if (armed) begin
            model_step(0);
            model_step(1);
        end
        if (mode == 1) begin
            if (req0[0]) aout0 = 16'h1234;
            else if (req0[1]) aout0 = 16'hFEDC;
        end
        rst_prev = reset;
        gcyc++;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < 2; c++) begin
                end_cnt[i][c] = 0; req_cnt[i][c] = 0;
            end
    endtask

    task automatic wait_phase(input int target);
        for (int n = 0; n < 800 && ph_of(0) != target; n++) cycle();
        chk("wait_phase", 0, ph_of(0), target);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            last_req[i] = 0; req_int[i] = 0; last_lr[i] = 0; lr_int[i] = 0;
            last_bclk[i] = 0; bclk_int[i] = 0; prev_lr[i] = 1'b1; prev_bclk[i] = 1'b0;
            edge_dac[i] = 1'b0; tcyc[i] = 0; men[i] = 2'b00; cap_pend[i] = 2'b00; mainv[i] = '0;
            for (int c = 0; c < 2; c++) begin
                msamp[i][c] = '0; end_val[i][c] = '0;
            end
        end
        clear_counts();
        word = '0; left_word = '0;
        reset = 1'b1; channel_en = 2'b11; aout0 = 16'hA5C3; aout1 = 24'h800001;
        nxt_reset = 1'b1; nxt_en = 2'b11;
        repeat (3) cycle();

        // held A5C3, both channels
        nxt_reset = 1'b0;
        repeat (3 * 384) cycle();
        chk("left_slot_bits", 0, left_word, 32'h52E18000);
        chk("req_period", 0, req_int[0], 384);
        chk("lrck_half_period", 0, lr_int[0], 192);
        chk("bclk_period", 0, bclk_int[0], 6);
        chk("i2s_msb_delayed", 0, edge_dac[0], 1'b0);
        chk("loopback_held", 0, end_val[0][0], 16'hA5C3);
        chk("req_period", 1, req_int[1], 192);
        chk("lrck_half_period", 1, lr_int[1], 96);
        chk("lj_msb_at_edge", 1, edge_dac[1], 1'b1);

        // per-channel samples switched on sample_req
        mode = 1;
        repeat (3 * 384) cycle();
        chk("loopback_left", 0, end_val[0][0], 16'h1234);
        chk("loopback_right", 0, end_val[0][1], 16'hFEDC);
        chk("loopback_left", 1, end_val[1][0], 24'h800001);
        chk("loopback_right", 1, end_val[1][1], 24'h800001);

        // right channel disabled, then re-enabled mid right slot
        nxt_en = 2'b01;
        repeat (384) cycle();
        clear_counts();
        repeat (2 * 384) cycle();
        chk("disabled_req1", 0, req_cnt[0][1], 0);
        chk("disabled_end1", 0, end_cnt[0][1], 0);
        chk("enabled_end0", 0, end_cnt[0][0], 2);
        wait_phase(32 * 6 + 10 * 6);
        nxt_en = 2'b11;
        clear_counts();
        wait_phase(0);
        chk("reenable_not_current", 0, end_cnt[0][1], 0);
        repeat (384) cycle();
        chk("reenable_next_slot", 0, end_cnt[0][1], 1);

        // reset at bit 10 of the left slot, held 3 clk
        wait_phase(10 * 6);
        nxt_reset = 1'b1;
        repeat (3) cycle();
        chk("rst_req", 0, req0, 2'b00);
        chk("rst_end", 0, end0, 2'b00);
        chk("rst_ain", 0, ain0, 16'h0000);
        chk("rst_lrck", 0, dlr0, 1'b1);
        chk("rst_bclk", 0, bclk0, 1'b0);
        chk("rst_dac", 0, dac0, 1'b0);
        nxt_reset = 1'b0;
        clear_counts();
        cycle();
        chk("first_req_after_reset", 0, req0, 2'b01);
        repeat (383) cycle();
        chk("first_frame_end0", 0, end_cnt[0][0], 1);
        chk("first_frame_end1", 0, end_cnt[0][1], 1);
        repeat (2 * 384) cycle();
        chk("req_period_after_reset", 0, req_int[0], 384);
        chk("loopback_left_after_reset", 0, end_val[0][0], 16'h1234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
